// File: rtl/systolic_os_array.sv
// Output-stationary signed GEMM engine: K skewed A/B beats, 2N-2 drain cycles, then N result rows.
// Input advances only on accepted beats; a stalled result row holds until out_ready.
module systolic_os_array #(
    parameter int  ARRAY_SIZE = 8,
    parameter int  DATA_WIDTH = 8,
    parameter int  K_MAX      = 64,
    localparam int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(K_MAX) + 1,
    localparam int KW         = $clog2(K_MAX+1),
    localparam int RW         = $clog2(ARRAY_SIZE)
) (
    input  logic                             clk,
    input  logic                             srstn,
    input  logic                             start,
    input  logic [KW-1:0]                    cfg_k,
    output logic                             busy,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_a,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_b,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [RW-1:0]                    out_row_idx,
    output logic [ARRAY_SIZE*ACC_WIDTH-1:0]  out_data,
    output logic                             done
);
    localparam int N   = ARRAY_SIZE;
    localparam int DW  = DATA_WIDTH;
    localparam int DCW = $clog2(2*N-1);
    localparam logic [KW-1:0] K_LIM = KW'(K_MAX);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUT} state_t;
    state_t state, state_nxt;

    logic [KW-1:0]  k_lat, beat_cnt;
    logic [DCW-1:0] drain_cnt;
    logic [RW-1:0]  row_idx;
    logic start_acc, beat_acc, adv, row_acc, last_beat, last_drain, last_row;

    assign start_acc  = start && (state == IDLE);
    assign beat_acc   = in_valid && (state == LOAD);
    assign adv        = beat_acc || (state == DRAIN);
    assign row_acc    = out_valid && out_ready;
    assign last_beat  = (beat_cnt == k_lat - KW'(1));
    assign last_drain = (drain_cnt == DCW'(2*N-3));
    assign last_row   = (row_idx == RW'(N-1));

    assign busy        = (state != IDLE);
    assign in_ready    = (state == LOAD);
    assign out_valid   = (state == OUT);
    assign out_row_idx = row_idx;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (cfg_k == '0) ? OUT : LOAD;
            LOAD:    if (beat_acc && last_beat) state_nxt = DRAIN;
            DRAIN:   if (last_drain) state_nxt = OUT;
            OUT:     if (row_acc && last_row) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            state     <= IDLE;
            k_lat     <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            row_idx   <= '0;
            done      <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= row_acc && last_row;
            if (start_acc) begin
                k_lat     <= (cfg_k > K_LIM) ? K_LIM : cfg_k;
                beat_cnt  <= '0;
                drain_cnt <= '0;
                row_idx   <= '0;
            end else begin
                if (beat_acc)         beat_cnt  <= beat_cnt + KW'(1);
                if (state == DRAIN)   drain_cnt <= drain_cnt + DCW'(1);
                if (row_acc)          row_idx   <= last_row ? '0 : row_idx + RW'(1);
            end
        end
    end

    logic signed [DW-1:0]        a_src  [N];
    logic signed [DW-1:0]        b_src  [N];
    logic signed [DW-1:0]        a_edge [N];
    logic signed [DW-1:0]        b_edge [N];
    logic signed [DW-1:0]        a_reg  [N][N];
    logic signed [DW-1:0]        b_reg  [N][N];
    logic signed [DW-1:0]        a_in   [N][N];
    logic signed [DW-1:0]        b_in   [N][N];
    logic signed [2*DW-1:0]      prod   [N][N];
    logic signed [ACC_WIDTH-1:0] acc    [N][N];

    // Lane i is delayed i stages so operand k of row i and column j meet in PE(i,j) together.
    for (genvar i = 0; i < N; i++) begin : g_skew
        assign a_src[i] = (state == LOAD) ? signed'(in_a[i*DW +: DW]) : '0;
        assign b_src[i] = (state == LOAD) ? signed'(in_b[i*DW +: DW]) : '0;
        if (i == 0) begin : g_direct
            assign a_edge[i] = a_src[i];
            assign b_edge[i] = b_src[i];
        end else begin : g_chain
            logic signed [DW-1:0] a_sr [i];
            logic signed [DW-1:0] b_sr [i];
            always_ff @(posedge clk) begin
                if (!srstn || start_acc) begin
                    for (int s = 0; s < i; s++) begin
                        a_sr[s] <= '0;
                        b_sr[s] <= '0;
                    end
                end else if (adv) begin
                    a_sr[0] <= a_src[i];
                    b_sr[0] <= b_src[i];
                    for (int s = 1; s < i; s++) begin
                        a_sr[s] <= a_sr[s-1];
                        b_sr[s] <= b_sr[s-1];
                    end
                end
            end
            assign a_edge[i] = a_sr[i-1];
            assign b_edge[i] = b_sr[i-1];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            if (j == 0) begin : g_a_edge
                assign a_in[i][j] = a_edge[i];
            end else begin : g_a_pass
                assign a_in[i][j] = a_reg[i][j-1];
            end
            if (i == 0) begin : g_b_edge
                assign b_in[i][j] = b_edge[j];
            end else begin : g_b_pass
                assign b_in[i][j] = b_reg[i-1][j];
            end
            assign prod[i][j] = a_in[i][j] * b_in[i][j];
        end
    end

    always_ff @(posedge clk) begin
        if (!srstn || start_acc) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_reg[i][j] <= '0;
                    b_reg[i][j] <= '0;
                    acc[i][j]   <= '0;
                end
            end
        end else if (adv) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_reg[i][j] <= a_in[i][j];
                    b_reg[i][j] <= b_in[i][j];
                    acc[i][j]   <= acc[i][j] + ACC_WIDTH'(prod[i][j]);
                end
            end
        end
    end

    always_comb begin
        out_data = '0;
        if (state == OUT) begin
            for (int j = 0; j < N; j++) begin
                out_data[j*ACC_WIDTH +: ACC_WIDTH] = acc[row_idx][j];
            end
        end
    end
endmodule

// File: tb/tb_systolic_os_array.sv
// Directed bench for systolic_os_array with a reference GEMM model feeding a row scoreboard.
module tb_systolic_os_array;
    localparam int N    = 8;
    localparam int DW   = 8;
    localparam int KMAX = 64;
    localparam int ACC  = 2*DW + $clog2(KMAX) + 1;
    localparam int KW   = $clog2(KMAX+1);
    localparam int RW   = $clog2(N);
    localparam int OW   = N*ACC;

    logic          clk = 1'b0;
    logic          srstn, start, busy, in_valid, in_ready, out_valid, out_ready, done;
    logic [KW-1:0] cfg_k;
    logic [N*DW-1:0] in_a, in_b;
    logic [RW-1:0] out_row_idx;
    logic [OW-1:0] out_data;

    int n_cmp = 0;
    int n_err = 0;
    int ma [N][KMAX];
    int mb [KMAX][N];
    logic [RW-1:0] exp_idx [$];
    logic [OW-1:0] exp_dat [$];

    always #5 clk = ~clk;

    systolic_os_array #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .K_MAX(KMAX)) dut (
        .clk(clk), .srstn(srstn), .start(start), .cfg_k(cfg_k), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_row_idx(out_row_idx),
        .out_data(out_data), .done(done)
    );

    task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_const(input int av, input int bv);
        for (int i = 0; i < N; i++) for (int k = 0; k < KMAX; k++) ma[i][k] = av;
        for (int k = 0; k < KMAX; k++) for (int j = 0; j < N; j++) mb[k][j] = bv;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < N; i++) for (int k = 0; k < KMAX; k++) ma[i][k] = int'($urandom_range(0, 255)) - 128;
        for (int k = 0; k < KMAX; k++) for (int j = 0; j < N; j++) mb[k][j] = int'($urandom_range(0, 255)) - 128;
    endtask

    task automatic fill_identity();
        for (int i = 0; i < N; i++) for (int k = 0; k < KMAX; k++) ma[i][k] = (i == k) ? 1 : 0;
        for (int k = 0; k < KMAX; k++) for (int j = 0; j < N; j++) mb[k][j] = 8*k + j - 32;
    endtask

    task automatic drive_beat(input int b);
        for (int i = 0; i < N; i++) begin
            in_a[i*DW +: DW] = 8'(ma[i][b]);
            in_b[i*DW +: DW] = 8'(mb[b][i]);
        end
    endtask

    task automatic run_job(input int kc, input bit rnd_in, input bit rnd_out, input bit poke);
        int keff, beats, guard, n, rows, s;
        bit v, rdy_o, rdy, vld, hold, poked;
        logic [OW-1:0] row, pd, d;
        logic [RW-1:0] pi, ix;
        keff = (kc > KMAX) ? KMAX : kc;
        for (int r = 0; r < N; r++) begin
            row = '0;
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int k = 0; k < keff; k++) s += ma[r][k] * mb[k][j];
                row[j*ACC +: ACC] = ACC'(s);
            end
            exp_idx.push_back(RW'(r));
            exp_dat.push_back(row);
        end
        @(negedge clk);
        start = 1'b1;
        cfg_k = KW'(kc);
        @(negedge clk);
        start = 1'b0;
        cfg_k = KW'($urandom_range(0, 100));
        chk("busy_after_start", busy, 1);
        chk("in_ready_after_start", in_ready, keff > 0);
        beats = 0;
        guard = 0;
        while (beats < keff && guard < 2000) begin
            v = rnd_in ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_valid = v;
            if (v) drive_beat(beats);
            else begin
                in_a = {$urandom(), $urandom()};
                in_b = {$urandom(), $urandom()};
            end
            rdy = in_ready;
            @(posedge clk);
            if (v && rdy) beats++;
            @(negedge clk);
            guard++;
        end
        chk("beats_accepted", beats, keff);
        in_valid = 1'b1;
        in_a = {$urandom(), $urandom()};
        in_b = {$urandom(), $urandom()};
        chk("in_ready_fall", in_ready, 0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_latency", n, (keff > 0) ? 2*N-2 : 0);
        rows = 0;
        guard = 0;
        hold = 1'b0;
        poked = 1'b0;
        pd = '0;
        pi = '0;
        while (rows < N && guard < 2000) begin
            rdy_o = rnd_out ? ($urandom_range(0, 2) != 0) : 1'b1;
            out_ready = rdy_o;
            if (poke && rows == 3 && !poked) begin
                start = 1'b1;
                cfg_k = KW'(5);
                poked = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (hold) begin
                chk("stall_data_stable", out_data, pd);
                chk("stall_idx_stable", out_row_idx, pi);
            end
            vld = out_valid;
            d = out_data;
            ix = out_row_idx;
            @(posedge clk);
            if (vld && rdy_o) begin
                if (exp_dat.size() == 0) chk("sb_underflow", 1, 0);
                else begin
                    chk("row_idx", ix, exp_idx.pop_front());
                    chk("row_data", d, exp_dat.pop_front());
                end
                rows++;
            end
            hold = vld && !rdy_o;
            pd = d;
            pi = ix;
            @(negedge clk);
            guard++;
        end
        start = 1'b0;
        chk("rows_out", rows, N);
        chk("done_pulse", done, 1);
        chk("busy_at_done", busy, 0);
        chk("out_valid_at_done", out_valid, 0);
        chk("sb_empty", exp_dat.size(), 0);
        out_ready = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", done, 0);
    endtask

    initial begin
        bit seen;
        srstn = 1'b0;
        start = 1'b0;
        cfg_k = '0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_row_idx", out_row_idx, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_done", done, 0);
        srstn = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        fill_identity();
        run_job(8, 0, 0, 1);
        fill_const(-128, -128);
        run_job(1, 0, 0, 0);
        fill_const(127, -128);
        run_job(1, 0, 0, 0);
        fill_const(-128, -128);
        run_job(64, 0, 0, 0);
        fill_rand();
        run_job(13, 1, 1, 0);

        fill_rand();
        @(negedge clk);
        start = 1'b1;
        cfg_k = KW'(10);
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < 5; b++) begin
            in_valid = 1'b1;
            drive_beat(b);
            @(negedge clk);
        end
        srstn = 1'b0;
        @(negedge clk);
        srstn = 1'b1;
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_row_idx", out_row_idx, 0);
        chk("abort_out_data", out_data, 0);
        chk("abort_done", done, 0);
        in_valid = 1'b0;
        seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (done || out_valid || busy) seen = 1'b1;
        end
        chk("abort_no_done", seen, 0);

        fill_rand();
        run_job(3, 1, 1, 0);
        run_job(0, 0, 1, 1);
        fill_rand();
        run_job(100, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
